// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared constants for the I2C target: FSM state encodings, R/W bit values,
// open-drain drive levels, and an address-compare helper.
// ---------------------------------------------------------------------------
package i2c_pkg;

    // Target FSM states (4-bit encoding, 0..7)
    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_ADDR      = 4'd1;
    localparam logic [3:0] S_ADDR_ACK  = 4'd2;
    localparam logic [3:0] S_RX        = 4'd3;
    localparam logic [3:0] S_RX_ACK    = 4'd4;
    localparam logic [3:0] S_TX        = 4'd5;
    localparam logic [3:0] S_TX_ACK    = 4'd6;
    localparam logic [3:0] S_WAIT_STOP = 4'd7;

    // R/W bit values
    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    // Open-drain drive levels
    localparam logic RELEASE = 1'b1;
    localparam logic PULL    = 1'b0;

    // Address byte = {addr[6:0], rw}. General call (7'h00) is accepted
    // only for writes, and only when gc_en is set.
    function automatic logic addr_match(input logic [7:0] addr_byte,
                                        input logic [6:0] own,
                                        input logic       gc_en);
        return (addr_byte[7:1] == own) ||
               (gc_en && (addr_byte[7:1] == 7'h00) && (addr_byte[0] == WRITE));
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// ---------------------------------------------------------------------------
// i2c_line_sync
// Synchronises sclk/sda into the clk domain and detects bus events.
// Each line passes SYNC_STAGES flops plus one history flop; events are
// decoded from (synchronised, history) pairs.
// Ports:
//   clk, rst        system clock, synchronous active-low reset
//   sclk_i, sda_i   raw bus lines
//   sda_sync        synchronised sda level (for sampling on sclk_rise)
//   sclk_rise/fall  one-clk pulses on synchronised sclk edges
//   start/stop      one-clk pulses: sda falls/rises while sclk held high
// ---------------------------------------------------------------------------
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sclk_i,
    input  logic sda_i,
    output logic sda_sync,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic start,
    output logic stop
);

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   sclk_hist_q;
    logic                   sda_hist_q;
    logic                   sclk_now;
    logic                   sda_now;

    // Reset to the idle bus level (both high) so no event fires out of reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            sclk_sync_q <= '1;
            sda_sync_q  <= '1;
            sclk_hist_q <= 1'b1;
            sda_hist_q  <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
            sda_sync_q  <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            sclk_hist_q <= sclk_sync_q[SYNC_STAGES-1];
            sda_hist_q  <= sda_sync_q[SYNC_STAGES-1];
        end
    end

    assign sclk_now  = sclk_sync_q[SYNC_STAGES-1];
    assign sda_now   = sda_sync_q[SYNC_STAGES-1];
    assign sda_sync  = sda_now;
    assign sclk_rise = sclk_now & ~sclk_hist_q;
    assign sclk_fall = ~sclk_now & sclk_hist_q;
    // sclk must be high in both samples so an sda move near an sclk edge
    // is not mistaken for START/STOP
    assign start     = sclk_now & sclk_hist_q & sda_hist_q & ~sda_now;
    assign stop      = sclk_now & sclk_hist_q & ~sda_hist_q & sda_now;

endmodule

// File: rtl/i2c_slave.sv
// ---------------------------------------------------------------------------
// i2c_slave
// I2C target with 7-bit address ADDR. Writes are ACKed and delivered on
// rx_data/rx_valid; reads shift out tx_data (or 8'hFF when no byte is ready).
// Optional build macro: I2C_SLAVE_GENERAL_CALL_EN -- when defined, address
// 7'h00 with rw=0 is also accepted as a write.
// Ports:
//   clk, rst           system clock, synchronous active-low reset
//   sclk, sda_in       bus clock and data as seen on the wire
//   sda_out            open-drain drive (0 = pull low, 1 = release)
//   tx_data/tx_valid   byte to return on read; tx_ack pulses when consumed
//   rx_data/rx_valid   last written byte; rx_valid pulses on update
//   rw                 R/W bit of the current transfer (1 = read)
//   state              current FSM state
//   busy               addressed transfer in progress
// ---------------------------------------------------------------------------
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDR        = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       sda_in,
    output logic       sda_out,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rw,
    output logic [3:0] state,
    output logic       busy
);

`ifdef I2C_SLAVE_GENERAL_CALL_EN
    localparam logic GC_EN = 1'b1;
`else
    localparam logic GC_EN = 1'b0;
`endif

    logic       sda_s, sclk_rise, sclk_fall, start_ev, stop_ev;

    logic [3:0] state_q, state_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [6:0] shift_q, shift_d;
    logic       sda_q, sda_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_ack_q, tx_ack_d;
    logic       rw_q, rw_d;
    logic       busy_q, busy_d;
    logic       phase_q, phase_d;
    logic [7:0] rx_byte;
    logic [7:0] tx_byte;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst       (rst),
        .sclk_i    (sclk),
        .sda_i     (sda_in),
        .sda_sync  (sda_s),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .start     (start_ev),
        .stop      (stop_ev)
    );

    assign rx_byte = {shift_q, sda_s};
    assign tx_byte = tx_valid ? tx_data : 8'hFF;

    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        sda_d      = sda_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_ack_d   = 1'b0;
        rw_d       = rw_q;
        busy_d     = busy_q;
        phase_d    = phase_q;

        if (start_ev) begin
            // START or repeated START: restart address phase, drop partial byte
            state_d  = S_ADDR;
            bitcnt_d = 3'd0;
            sda_d    = RELEASE;
            phase_d  = 1'b0;
        end else if (stop_ev) begin
            state_d  = S_IDLE;
            bitcnt_d = 3'd0;
            sda_d    = RELEASE;
            busy_d   = 1'b0;
            phase_d  = 1'b0;
        end else begin
            case (state_q)
                S_ADDR: if (sclk_rise) begin
                    shift_d  = rx_byte[6:0];
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        if (addr_match(rx_byte, ADDR, GC_EN)) begin
                            state_d = S_ADDR_ACK;
                            rw_d    = rx_byte[0];
                            busy_d  = 1'b1;
                        end else begin
                            state_d = S_WAIT_STOP;
                            busy_d  = 1'b0;
                        end
                    end
                end
                // ACK slots: first falling edge pulls low, second releases.
                // sda_q itself tells which of the two edges this is.
                S_ADDR_ACK: if (sclk_fall) begin
                    if (sda_q == RELEASE) begin
                        sda_d = PULL;
                    end else if (rw_q == READ) begin
                        shift_d  = tx_byte[6:0];
                        sda_d    = tx_byte[7];
                        tx_ack_d = tx_valid;
                        bitcnt_d = 3'd0;
                        state_d  = S_TX;
                    end else begin
                        sda_d   = RELEASE;
                        state_d = S_RX;
                    end
                end
                S_RX: if (sclk_rise) begin
                    shift_d  = rx_byte[6:0];
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        rx_data_d  = rx_byte;
                        rx_valid_d = 1'b1;
                        state_d    = S_RX_ACK;
                    end
                end
                S_RX_ACK: if (sclk_fall) begin
                    if (sda_q == RELEASE) begin
                        sda_d = PULL;
                    end else begin
                        sda_d   = RELEASE;
                        state_d = S_RX;
                    end
                end
                S_TX: begin
                    if (sclk_rise) begin
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            state_d = S_TX_ACK;
                            phase_d = 1'b0;
                        end
                    end else if (sclk_fall) begin
                        sda_d   = shift_q[6];
                        shift_d = {shift_q[5:0], 1'b0};
                    end
                end
                // phase_q=0: release after bit 8; phase_q=1: master ACKed,
                // load the next byte at the falling edge closing the ACK slot
                S_TX_ACK: begin
                    if (sclk_rise) begin
                        if (sda_s) state_d = S_WAIT_STOP;
                        else       phase_d = 1'b1;
                    end else if (sclk_fall) begin
                        if (phase_q) begin
                            shift_d  = tx_byte[6:0];
                            sda_d    = tx_byte[7];
                            tx_ack_d = tx_valid;
                            bitcnt_d = 3'd0;
                            phase_d  = 1'b0;
                            state_d  = S_TX;
                        end else begin
                            sda_d = RELEASE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            bitcnt_q   <= 3'd0;
            sda_q      <= RELEASE;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            tx_ack_q   <= 1'b0;
            rw_q       <= WRITE;
            busy_q     <= 1'b0;
            phase_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            sda_q      <= sda_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_ack_q   <= tx_ack_d;
            rw_q       <= rw_d;
            busy_q     <= busy_d;
            phase_q    <= phase_d;
        end
    end

    // Shift register carries only data; its contents are don't-care until loaded
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign sda_out  = sda_q;
    assign tx_ack   = tx_ack_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rw       = rw_q;
    assign state    = state_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// ---------------------------------------------------------------------------
// tb_i2c_slave
// Directed bench for i2c_slave: an in-bench I2C master bit-bangs sclk/sda
// (8 clk low and 8 clk high per bus phase); the wire is the AND of master
// and target drives.
// ---------------------------------------------------------------------------
module tb_i2c_slave;

    localparam logic [3:0] ST_IDLE = 4'd0;
    localparam logic [3:0] ST_TX   = 4'd5;
    localparam logic [3:0] ST_WAIT = 4'd7;

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk;
    logic       m_sda;
    logic       sda_in;
    logic       sda_out;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rw;
    logic [3:0] state;
    logic       busy;

    int checks = 0;
    int errors = 0;

    int rxv_cnt = 0, rxv_dbl = 0, txa_cnt = 0, txa_dbl = 0;
    int low_cnt = 0, busy_cnt = 0, viol = 0;
    logic rxv_prev = 1'b0, txa_prev = 1'b0, sda_prev = 1'b1, sclk_prev = 1'b1;

    assign sda_in = m_sda & sda_out;

    always #5 clk = ~clk;

    i2c_slave #(.ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .sclk     (sclk),
        .sda_in   (sda_in),
        .sda_out  (sda_out),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ack   (tx_ack),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rw       (rw),
        .state    (state),
        .busy     (busy)
    );

    // Event monitor
    always @(negedge clk) begin
        if (rx_valid) rxv_cnt <= rxv_cnt + 1;
        if (rx_valid && rxv_prev) rxv_dbl <= rxv_dbl + 1;
        if (tx_ack) txa_cnt <= txa_cnt + 1;
        if (tx_ack && txa_prev) txa_dbl <= txa_dbl + 1;
        if (!sda_out) low_cnt <= low_cnt + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
        if (rst && sclk && sclk_prev && (sda_out !== sda_prev)) viol <= viol + 1;
        rxv_prev  <= rx_valid;
        txa_prev  <= tx_ack;
        sda_prev  <= sda_out;
        sclk_prev <= sclk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_bit(input logic b, output logic s);
        ticks(4); m_sda = b;
        ticks(4); sclk = 1'b1;
        ticks(8); s = sda_in;
        sclk = 1'b0;
    endtask

    task automatic bus_start();
        ticks(4); m_sda = 1'b1;
        ticks(4); sclk = 1'b1;
        ticks(8); m_sda = 1'b0;
        ticks(8); sclk = 1'b0;
    endtask

    task automatic bus_stop();
        ticks(4); m_sda = 1'b0;
        ticks(4); sclk = 1'b1;
        ticks(8); m_sda = 1'b1;
        ticks(8);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
        bus_bit(1'b1, ack);
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] d);
        logic s;
        d = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, s);
            d[i] = s;
        end
        bus_bit(mack, s);
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        int         rx0, tx0, low0, busy0;

        rst = 1'b0; sclk = 1'b1; m_sda = 1'b1; tx_data = 8'h00; tx_valid = 1'b0;
        ticks(3);
        check("rst_sda_out",  sda_out,  1'b1);
        check("rst_tx_ack",   tx_ack,   1'b0);
        check("rst_rx_data",  rx_data,  8'h00);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_rw",       rw,       1'b0);
        check("rst_busy",     busy,     1'b0);
        check("rst_state",    state,    ST_IDLE);
        rst = 1'b1;
        ticks(6);

        // Write: A0, A6
        rx0 = rxv_cnt;
        bus_start();
        send_byte(8'hA0, ack);
        check("wr_addr_ack", ack, 1'b0);
        check("wr_busy", busy, 1'b1);
        check("wr_rw", rw, 1'b0);
        send_byte(8'hA6, ack);
        check("wr_data_ack", ack, 1'b0);
        check("wr_rx_data", rx_data, 8'hA6);
        bus_stop();
        check("wr_rxv_count", rxv_cnt - rx0, 1);
        check("wr_rxv_width", rxv_dbl, 0);
        check("wr_end_state", state, ST_IDLE);
        check("wr_end_busy", busy, 1'b0);

        // Read: A1, return F6, master NACK
        tx0 = txa_cnt;
        tx_data = 8'hF6; tx_valid = 1'b1;
        bus_start();
        send_byte(8'hA1, ack);
        check("rd_addr_ack", ack, 1'b0);
        check("rd_rw", rw, 1'b1);
        recv_byte(1'b1, d);
        check("rd_byte", d, 8'hF6);
        check("rd_state_nack", state, ST_WAIT);
        check("rd_tx_ack_count", txa_cnt - tx0, 1);
        check("rd_tx_ack_width", txa_dbl, 0);
        tx_valid = 1'b0;
        bus_stop();
        check("rd_end_state", state, ST_IDLE);

        // Wrong address: A4
        rx0 = rxv_cnt; low0 = low_cnt; busy0 = busy_cnt;
        bus_start();
        send_byte(8'hA4, ack);
        check("na_ack", ack, 1'b1);
        check("na_sda_low_cycles", low_cnt - low0, 0);
        check("na_busy_cycles", busy_cnt - busy0, 0);
        check("na_state", state, ST_WAIT);
        bus_stop();
        check("na_end_state", state, ST_IDLE);
        check("na_rxv_count", rxv_cnt - rx0, 0);

        // Repeated START after 4 RX bits, then read with no tx byte ready
        rx0 = rxv_cnt;
        bus_start();
        send_byte(8'hA0, ack);
        check("rs_addr_ack", ack, 1'b0);
        for (int i = 0; i < 4; i++) bus_bit(1'b0, ack);
        bus_start();
        send_byte(8'hA1, ack);
        check("rs_addr2_ack", ack, 1'b0);
        check("rs_rw", rw, 1'b1);
        ticks(5);
        check("rs_state_tx", state, ST_TX);
        recv_byte(1'b1, d);
        check("rs_byte_ff", d, 8'hFF);
        bus_stop();
        check("rs_rxv_count", rxv_cnt - rx0, 0);

        // Reset while pulling sda low mid-TX
        tx_data = 8'h0F; tx_valid = 1'b1;
        bus_start();
        send_byte(8'hA1, ack);
        ticks(5);
        tx_valid = 1'b0;
        check("rt_pre_sda", sda_out, 1'b0);
        check("rt_pre_state", state, ST_TX);
        rst = 1'b0;
        ticks(1);
        check("rt_sda", sda_out, 1'b1);
        check("rt_state", state, ST_IDLE);
        check("rt_busy", busy, 1'b0);
        rst = 1'b1;
        m_sda = 1'b1;
        ticks(4); sclk = 1'b1;
        ticks(10);

        // General call address 0x00 write
        rx0 = rxv_cnt;
        bus_start();
        send_byte(8'h00, ack);
`ifdef I2C_SLAVE_GENERAL_CALL_EN
        check("gc_addr_ack", ack, 1'b0);
        send_byte(8'h5A, ack);
        check("gc_data_ack", ack, 1'b0);
        check("gc_rx_data", rx_data, 8'h5A);
        check("gc_rxv_count", rxv_cnt - rx0, 1);
`else
        check("gc_addr_nack", ack, 1'b1);
        send_byte(8'h5A, ack);
        check("gc_data_nack", ack, 1'b1);
        check("gc_rxv_count", rxv_cnt - rx0, 0);
`endif
        bus_stop();
        check("gc_end_state", state, ST_IDLE);

        check("sda_change_while_sclk_high", viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
